// File: rtl/prog_mem_loader.sv
// Writable program memory with byte-stream loader; reads are combinational
// like the fixed ROM it replaces, unwritten words return DEFAULT_WORD.
module prog_mem_loader #(
  parameter int ROM_WIDTH = 21,
  parameter int ADDR_WIDTH = 6,
  parameter logic [ROM_WIDTH-1:0] DEFAULT_WORD = 21'b010010000000000001000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [15:0]           ADDR,
  output logic [ROM_WIDTH-1:0]  data,
  input  logic                  load_start,
  input  logic                  load_end,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  cpu_hold,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int BPW = (ROM_WIDTH + 7) / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_LOAD = 1'b1;

  logic [0:0]            r_state;
  logic [DEPTH-1:0]      r_valid;
  logic [ROM_WIDTH-1:0]  r_mem [DEPTH];
  logic [BPW*8-1:0]      r_asm;
  logic [BCW-1:0]        r_byte_cnt;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH:0]   r_words;

  logic                  w_xfer;
  logic                  w_last;
  logic                  w_full_mem;
  logic [BPW*8-1:0]      w_full;
  logic [15:0]           w_hi;
  logic [ADDR_WIDTH-1:0] w_idx;

  assign w_xfer = (r_state == S_LOAD) && in_valid;
  assign w_last = w_xfer && (r_byte_cnt == BCW'(BPW - 1));
  assign w_full_mem = (r_wr_addr == ADDR_WIDTH'(DEPTH - 1));

  // Current lane replaced by the incoming byte, little-endian.
  always_comb begin
    w_full = r_asm;
    w_full[{r_byte_cnt, 3'b000} +: 8] = in_byte;
  end

  if (BPW * 8 > ROM_WIDTH) begin : g_pad
    logic w_unused_pad;
    assign w_unused_pad = ^w_full[BPW*8-1:ROM_WIDTH];
  end

  assign w_hi = ADDR >> ADDR_WIDTH;
  assign w_idx = ADDR[ADDR_WIDTH-1:0];
  assign data = ((w_hi == 16'd0) && r_valid[w_idx]) ? r_mem[w_idx]
                                                      : DEFAULT_WORD;

  assign in_ready = (r_state == S_LOAD);
  assign cpu_hold = (r_state == S_LOAD);
  assign words_loaded = r_words;

  // Storage needs no reset; the valid vector masks stale contents.
  always_ff @(posedge CLK) begin
    if (w_last && !load_start) begin
      r_mem[r_wr_addr] <= w_full[ROM_WIDTH-1:0];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_RUN;
      r_valid    <= '0;
      r_asm      <= '0;
      r_byte_cnt <= '0;
      r_wr_addr  <= '0;
      r_words    <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (load_start) begin
            r_state    <= S_LOAD;
            r_valid    <= '0;
            r_asm      <= '0;
            r_byte_cnt <= '0;
            r_wr_addr  <= '0;
            r_words    <= '0;
          end
        end
        S_LOAD: begin
          if (load_start) begin
            r_valid    <= '0;
            r_asm      <= '0;
            r_byte_cnt <= '0;
            r_wr_addr  <= '0;
            r_words    <= '0;
          end else begin
            if (w_last) begin
              r_valid[r_wr_addr] <= 1'b1;
              r_words            <= r_words + 1'b1;
              r_byte_cnt         <= '0;
              if (w_full_mem) begin
                r_state <= S_RUN;
              end else begin
                r_wr_addr <= r_wr_addr + 1'b1;
              end
            end else if (w_xfer) begin
              r_asm      <= w_full;
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
            // A partial word is dropped when the load ends.
            if (load_end) begin
              r_state    <= S_RUN;
              r_byte_cnt <= '0;
            end
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: directed scenarios plus random traffic,
// checked against a byte-count based reference model.
module tb_prog_mem_loader;

  localparam int RW = 21;
  localparam int AW = 6;
  localparam int DEPTH = 64;
  localparam int BPW = 3;
  localparam logic [RW-1:0] DEF = 21'b010010000000000001000;

  logic          CLK;
  logic          RST;
  logic [15:0]   ADDR;
  logic [RW-1:0] data;
  logic          load_start;
  logic          load_end;
  logic [7:0]    in_byte;
  logic          in_valid;
  logic          in_ready;
  logic          cpu_hold;
  logic [AW:0]   words_loaded;

  prog_mem_loader dut (
    .CLK(CLK),
    .RST(RST),
    .ADDR(ADDR),
    .data(data),
    .load_start(load_start),
    .load_end(load_end),
    .in_byte(in_byte),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .cpu_hold(cpu_hold),
    .words_loaded(words_loaded)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;

  logic [RW-1:0] m_mem [DEPTH];
  bit   [DEPTH-1:0] m_valid;
  int   m_nb;
  bit   m_loading;
  logic [23:0] m_pend;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] exp_data(input int a);
    if (a < DEPTH && m_valid[a]) return m_mem[a];
    return DEF;
  endfunction

  task automatic model_reset();
    m_valid = '0;
    m_nb = 0;
    m_loading = 0;
    m_pend = '0;
  endtask

  // Spec-level model: track total bytes accepted in the current load.
  task automatic model_edge(input bit st, input bit en, input bit v,
                            input logic [7:0] b);
    int lane;
    int idx;
    if (st) begin
      m_valid = '0;
      m_nb = 0;
      m_loading = 1;
    end else if (m_loading) begin
      if (v) begin
        lane = m_nb % BPW;
        m_pend[lane*8 +: 8] = b;
        m_nb++;
        if (m_nb % BPW == 0) begin
          idx = m_nb / BPW - 1;
          m_mem[idx] = m_pend[RW-1:0];
          m_valid[idx] = 1'b1;
          if (idx == DEPTH - 1) m_loading = 0;
        end
      end
      if (en) m_loading = 0;
    end
  endtask

  task automatic chk_ctrl(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_loading));
    chk({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(m_loading));
    chk({tag, ".words"}, 32'(words_loaded), 32'(m_nb / BPW));
  endtask

  task automatic chk_addr(input int a);
    ADDR = 16'(a);
    #1;
    chk($sformatf("data@%0d", a), 32'(data), 32'(exp_data(a)));
  endtask

  task automatic sweep();
    for (int a = 0; a < DEPTH; a++) chk_addr(a);
    chk_addr(64);
    chk_addr(16'hffff);
    @(posedge CLK);
    #1;
  endtask

  task automatic cyc(input bit st, input bit en, input bit v,
                     input logic [7:0] b);
    load_start = st;
    load_end = en;
    in_valid = v;
    in_byte = b;
    @(posedge CLK);
    model_edge(st, en, v, b);
    #1;
    load_start = 0;
    load_end = 0;
    in_valid = 0;
  endtask

  int guard;
  logic [7:0] b0, b1, b2;

  initial begin
    RST = 1; ADDR = 0; load_start = 0; load_end = 0;
    in_byte = 0; in_valid = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RST = 0;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst.words", 32'(words_loaded), 32'd0);
    sweep();

    // Single known word, then end.
    cyc(1, 0, 0, 0);
    chk_ctrl("w1.start");
    chk("w1.hold_hi", 32'(cpu_hold), 32'd1);
    cyc(0, 0, 1, 8'h05); chk_ctrl("w1.b0");
    cyc(0, 0, 1, 8'h00); chk_ctrl("w1.b1");
    cyc(0, 0, 1, 8'h1D); chk_ctrl("w1.b2");
    cyc(0, 1, 0, 0);
    chk_ctrl("w1.end");
    chk("w1.hold_lo", 32'(cpu_hold), 32'd0);
    chk("w1.words", 32'(words_loaded), 32'd1);
    ADDR = 0; #1;
    chk("w1.data0", 32'(data), 32'(21'b111010000000000000101));
    ADDR = 1; #1;
    chk("w1.data1", 32'(data), 32'(DEF));

    // Two words plus a partial word.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 8'($urandom));
      chk_ctrl("p2.byte");
    end
    cyc(0, 1, 0, 0);
    chk("p2.words", 32'(words_loaded), 32'd2);
    ADDR = 2; #1;
    chk("p2.data2", 32'(data), 32'(DEF));
    sweep();

    // Full memory with gaps in in_valid.
    cyc(1, 0, 0, 0);
    guard = 0;
    while (m_loading && guard < 2000) begin
      cyc(0, 0, ($urandom_range(0, 3) != 0), 8'($urandom));
      chk_ctrl("full.byte");
      guard++;
    end
    chk("full.timeout", 32'(guard < 2000), 32'd1);
    chk("full.in_ready", 32'(in_ready), 32'd0);
    chk("full.words", 32'(words_loaded), 32'd64);
    cyc(0, 0, 1, 8'hFF);
    chk_ctrl("full.after");
    sweep();

    // Asynchronous reset after 10 words.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 31; i++) cyc(0, 0, 1, 8'($urandom));
    chk("arst.words_pre", 32'(words_loaded), 32'd10);
    RST = 1;
    #1;
    model_reset();
    chk("arst.in_ready", 32'(in_ready), 32'd0);
    chk("arst.cpu_hold", 32'(cpu_hold), 32'd0);
    chk("arst.words", 32'(words_loaded), 32'd0);
    ADDR = 3; #1;
    chk("arst.data3", 32'(data), 32'(DEF));
    RST = 0;
    sweep();

    // Restart with one byte pending; the byte on that edge is dropped.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 8'($urandom));
    cyc(1, 0, 1, 8'hAA);
    chk_ctrl("rs.restart");
    chk("rs.words", 32'(words_loaded), 32'd0);
    ADDR = 0; #1;
    chk("rs.data0", 32'(data), 32'(DEF));
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
    cyc(0, 0, 1, b0);
    cyc(0, 0, 1, b1);
    cyc(0, 1, 1, b2);
    chk_ctrl("le.end");
    chk("le.words", 32'(words_loaded), 32'd1);
    ADDR = 0; #1;
    chk("le.data0", 32'(data), 32'({b2[4:0], b1, b0}));

    // load_start wins over load_end.
    cyc(1, 1, 0, 0);
    chk("se.in_ready", 32'(in_ready), 32'd1);
    cyc(0, 1, 0, 0);
    chk_ctrl("se.end");

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 3) != 0), 8'($urandom));
      chk_ctrl("rnd");
      chk_addr(int'($urandom_range(0, 70)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_mem_loader.md
# prog_mem_loader

Parametrised, writable successor to the fixed case-based program ROM: a DEPTH-word instruction memory that the instruction-fetch unit reads asynchronously, exactly as it reads the ROM, and that a host loads at run time through a byte-wide valid/ready stream. While a load is in progress the block holds the CPU. Locations not written since the last load or reset return a parametrised default instruction, by default the jump used as the ROM's fallback word.

## Interface
- ROM_WIDTH, 21, instruction word width in bits
- ADDR_WIDTH, 6, memory address width; DEPTH = 2**ADDR_WIDTH words
- DEFAULT_WORD, 21'b010010000000000001000, value returned for unwritten locations
- Derived constant BPW = ceil(ROM_WIDTH/8), the number of bytes per word (3 at defaults)

- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- ADDR  in  16  fetch address; bits above ADDR_WIDTH-1 must be zero, otherwise data = DEFAULT_WORD
- data  out  ROM_WIDTH  fetched instruction, combinational from ADDR and memory state
- load_start  in  1  single-cycle pulse; begins (or restarts) a load
- load_end  in  1  single-cycle pulse; ends the load
- in_byte  in  8  load data byte
- in_valid  in  1  in_byte valid
- in_ready  out  1  block accepts in_byte; a transfer occurs when in_valid && in_ready on a clock edge
- cpu_hold  out  1  high while loading; the CPU must stall its PC
- words_loaded  out  ADDR_WIDTH+1  number of complete words written by the current or last load

## Operation
- Storage: a DEPTH x ROM_WIDTH array, plus a DEPTH-bit valid vector.
  - data = mem[ADDR] if valid[ADDR], otherwise DEFAULT_WORD.
- FSM with two states: RUN (reset state) and LOAD.
- RUN:
  - in_ready = 0, cpu_hold = 0.
  - load_start -> LOAD. On that edge: clear the entire valid vector, wr_addr = 0, byte_cnt = 0, words_loaded = 0.
- LOAD:
  - in_ready = 1, cpu_hold = 1.
  - Each transfer places in_byte into byte lane byte_cnt of the assembly register, little-endian (byte 0 = bits 7:0).
  - Bits of the last byte above ROM_WIDTH-1 are discarded.
  - byte_cnt increments on each transfer.
  - On the transfer with byte_cnt == BPW-1:
    - mem[wr_addr] = assembled word, and valid[wr_addr] = 1.
    - wr_addr and words_loaded increment; byte_cnt = 0.
  - load_end -> RUN. Any partial word (byte_cnt != 0) is discarded and not written.
  - Full: when the word written is at wr_addr == DEPTH-1, go to RUN on the same edge. words_loaded = DEPTH; wr_addr does not wrap.
  - load_start while in LOAD restarts the load: valid cleared, counters zeroed, stay in LOAD.
- Simultaneous events on one edge:
  - load_end with a word-completing transfer: the word is written, then RUN.
  - load_start with a transfer: load_start wins and the byte is dropped.
  - load_start with load_end: load_start wins.

## Timing
- Reset values: state RUN, valid all 0 (so data = DEFAULT_WORD for every ADDR), in_ready 0, cpu_hold 0, words_loaded 0, byte_cnt 0, wr_addr 0. mem contents are don't-care.
- Reset is asynchronous. Assertion mid-load immediately returns the block to RUN with all valid bits cleared, so a partially loaded program is invalidated.
- cpu_hold and in_ready rise in the cycle after the load_start edge.
  - They fall in the cycle after the load_end edge, or after the edge that completes the full-memory write.
- A written word is visible on data (combinationally, for a matching ADDR) from the cycle after its final byte's edge.
- Throughput: one byte per cycle; BPW cycles per word.
- Read latency is 0 cycles (combinational), identical to the ROM it replaces.

## Test plan
- Reset, then sweep ADDR 0..63 -> data = 21'b010010000000000001000 everywhere; in_ready = 0, cpu_hold = 0, words_loaded = 0.
- load_start, then bytes 05,00,1D (word 21'b111010000000000000101), then load_end -> data@0 = 0x1D0005 masked to 21 bits; data@1 = DEFAULT_WORD; words_loaded = 1; cpu_hold high for exactly the load window.
- Load 2 full words plus 2 bytes, then load_end -> words_loaded = 2; address 2 still reads DEFAULT_WORD.
- Stream 192 bytes with in_valid held high and in_valid gaps inserted -> all 64 words readable; automatic return to RUN after byte 192; words_loaded = 64; in_ready low on the next cycle.
- Assert RST after 10 words have loaded -> immediate return to RUN; all addresses read DEFAULT_WORD; words_loaded = 0.
- Same-edge cases:
  - load_start during LOAD with 1 byte pending -> counters reset; previously loaded words read DEFAULT_WORD.
  - load_end on the third byte -> that word is written.
